sram_uart_tx_interface: RTL and testbench
=========================================

SRAM_UART_TX_INTERFACE -- requirements
Module: sram_uart_tx_interface

Interface
REQ-001 Parameter: CLOCKS_PER_BIT, 434, Clock cycles per UART bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Port: Clock  input  1  system clock, all logic on its rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: Start  input  1  transfer request, sampled only in S_TX_IDLE.
REQ-005 Port: Base_address  input  18  first SRAM word address, latched on an accepted Start.
REQ-006 Port: Word_count  input  18  number of 16-bit words to send, latched on an accepted Start.
REQ-007 Port: SRAM_read_data  input  16  read data from the SRAM controller.
REQ-008 Port: SRAM_address  output  18  SRAM read address.
REQ-009 Port: SRAM_write_data  output  16  constant 16'd0.
REQ-010 Port: SRAM_we_n  output  1  constant 1 (read-only master).
REQ-011 Port: UART_TX_O  output  1  serial line, idle high.
REQ-012 Port: Busy  output  1  high from the cycle after an accepted Start until Done.
REQ-013 Port: Done  output  1  one-cycle pulse at transfer completion.

Function
REQ-014 The block SHALL implement the following states: S_TX_IDLE, S_TX_RD0, S_TX_RD1, S_TX_RD2, S_TX_START, S_TX_DATA, S_TX_PARITY (present only when the macro is defined), and S_TX_STOP.
REQ-015 In S_TX_IDLE, Start=1 with Word_count≠0 SHALL latch Base_address and Word_count, set Busy, and go to S_TX_RD0.
REQ-016 In S_TX_IDLE, Start=1 with Word_count=0 SHALL pulse Done on the next cycle, leave Busy at 0, and keep UART_TX_O at 1.
REQ-017 Start while Busy SHALL be ignored; latched values SHALL NOT change.
REQ-018 SRAM_address SHALL hold the current word address from S_TX_RD0; read data is valid 2 cycles later, and S_TX_RD2 SHALL capture SRAM_read_data into the word register.
REQ-019 Each word SHALL be sent as two bytes, [15:8] first then [7:0], each byte LSB first.
REQ-020 Each byte frame SHALL be: start bit 0, 8 data bits, optional parity bit, stop bit 1; every bit SHALL last exactly CLOCKS_PER_BIT cycles, timed by a bit counter and a bit-index counter.
REQ-021 After the high-byte stop bit completes, the block SHALL go to S_TX_START for the low byte.
REQ-022 After the low-byte stop bit completes, if words remain: address+1 (mod 2^18), remaining count-1, then S_TX_RD0.
REQ-023 After the low-byte stop bit completes, if no words remain: Done=1 for one cycle, Busy=0, then S_TX_IDLE.
REQ-024 UART_TX_O SHALL be 1 in S_TX_IDLE and S_TX_RD0..RD2, so inter-word gaps are idle-high (3 cycles).
REQ-025 UART_TX_O SHALL be driven from a register, so it is glitch-free.
REQ-026 Address wrap-around from 18'h3FFFF to 18'h00000 SHALL be silent.
REQ-027 Total cycles from the accepted Start to Done SHALL equal N*(3 + 2*F*CLOCKS_PER_BIT) + 1, where N is the word count and F = 10 (11 with parity).

Reset
REQ-028 Reset=1 SHALL immediately force S_TX_IDLE and set UART_TX_O=1, Busy=0, Done=0, SRAM_address=0, and all counters and the word register to 0, including mid-frame.
REQ-029 After Reset deasserts, the block SHALL accept Start on the first clock edge.

Configuration
REQ-030 Macro SRAM_UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) SHALL be inserted between bit 7 and the stop bit (8E1, F=11).
REQ-031 Macro SRAM_UART_TX_PARITY_EN undefined: S_TX_PARITY SHALL be absent, and frames SHALL be 8N1 (F=10).

Verification
REQ-032 CLOCKS_PER_BIT=4, no parity, Base=0x00010, Count=1, SRAM[0x10]=0xA55A -> line carries 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1 (4 cycles per bit); Done 84 cycles after Start.
REQ-033 Count=0 with Start -> Done pulse next cycle; Busy stays 0; UART_TX_O stays 1.
REQ-034 Base=0x3FFFF, Count=2 -> second read at address 0x00000.
REQ-035 Start re-asserted mid-transfer -> ignored; byte stream and Done timing unchanged.
REQ-036 Reset asserted during the data bits of byte 1 -> UART_TX_O=1 and Busy=0 in the same cycle; a fresh Start afterwards transmits correctly.
REQ-037 With SRAM_UART_TX_PARITY_EN, SRAM word 0x0700 -> high byte parity bit 1, low byte parity bit 0; Done 92 cycles after Start (CLOCKS_PER_BIT=4).

Source files
------------

// File: rtl/sram_uart_tx_interface_if.sv
// Bus bundle between the SRAM-to-UART transmitter and its surroundings.
// slave = transmitter side, master = controller/SRAM/line side.
interface sram_uart_tx_interface_if;
  logic        Start;
  logic [17:0] Base_address;
  logic [17:0] Word_count;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  modport slave (
    input  Start, Base_address, Word_count, SRAM_read_data,
    output SRAM_address, SRAM_write_data, SRAM_we_n, UART_TX_O, Busy, Done
  );

  modport master (
    output Start, Base_address, Word_count, SRAM_read_data,
    input  SRAM_address, SRAM_write_data, SRAM_we_n, UART_TX_O, Busy, Done
  );
endinterface

// File: rtl/sram_uart_tx_interface.sv
// Reads Word_count 16-bit words from SRAM and sends each as two UART bytes (high first).
// Define SRAM_UART_TX_PARITY_EN for 8E1 frames; default build sends 8N1.
module sram_uart_tx_interface #(
  parameter int unsigned CLOCKS_PER_BIT = 434
) (
  input  logic                       Clock,
  input  logic                       Reset,
  sram_uart_tx_interface_if.slave    bus,
  output logic [2:0]                 dbg_state_o
);

  // Handshake: Start is a request sampled only while idle; Busy covers the
  // whole transfer and Done pulses for exactly one cycle when it ends.

  typedef enum logic [2:0] {
    S_TX_IDLE   = 3'd0,
    S_TX_RD0    = 3'd1,
    S_TX_RD1    = 3'd2,
    S_TX_RD2    = 3'd3,
    S_TX_START  = 3'd4,
    S_TX_DATA   = 3'd5,
`ifdef SRAM_UART_TX_PARITY_EN
    S_TX_PARITY = 3'd6,
`endif
    S_TX_STOP   = 3'd7
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(CLOCKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [17:0] addr_q, addr_d;
  logic [17:0] cnt_q, cnt_d;
  logic [15:0] word_q, word_d;
  logic        byte_sel_q, byte_sel_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  cur_byte_d;
  logic        bit_last;

  assign bit_last = (bit_cnt_q == LAST_CNT);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_TX_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      byte_sel_q <= 1'b0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      byte_sel_q <= byte_sel_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    byte_sel_d = byte_sel_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_d       = 1'b1;
    cur_byte_d = 8'h00;

    case (state_q)
      S_TX_IDLE: begin
        if (bus.Start) begin
          if (bus.Word_count != 18'd0) begin
            addr_d  = bus.Base_address;
            cnt_d   = bus.Word_count;
            busy_d  = 1'b1;
            state_d = S_TX_RD0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_TX_RD0: state_d = S_TX_RD1;
      S_TX_RD1: state_d = S_TX_RD2;
      S_TX_RD2: begin
        // SRAM data for the address presented in RD0 arrives here.
        word_d     = bus.SRAM_read_data;
        byte_sel_d = 1'b0;
        bit_cnt_d  = '0;
        state_d    = S_TX_START;
      end
      S_TX_START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_TX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      S_TX_DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef SRAM_UART_TX_PARITY_EN
            state_d = S_TX_PARITY;
`else
            state_d = S_TX_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
`ifdef SRAM_UART_TX_PARITY_EN
      S_TX_PARITY: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          state_d   = S_TX_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
`endif
      S_TX_STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = S_TX_START;
          end else if (cnt_q != 18'd1) begin
            addr_d     = addr_q + 18'd1;
            cnt_d      = cnt_q - 18'd1;
            byte_sel_d = 1'b0;
            state_d    = S_TX_RD0;
          end else begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            byte_sel_d = 1'b0;
            state_d    = S_TX_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      default: state_d = S_TX_IDLE;
    endcase

    // The line register is loaded with the bit that belongs to the next state,
    // so the serial output changes exactly on the state transition edge.
    cur_byte_d = byte_sel_d ? word_d[7:0] : word_d[15:8];
    case (state_d)
      S_TX_START:  tx_d = 1'b0;
      S_TX_DATA:   tx_d = cur_byte_d[bit_idx_d];
`ifdef SRAM_UART_TX_PARITY_EN
      S_TX_PARITY: tx_d = ^cur_byte_d;
`endif
      default:     tx_d = 1'b1;
    endcase
  end

  assign bus.SRAM_address    = addr_q;
  assign bus.SRAM_write_data = 16'd0;
  assign bus.SRAM_we_n       = 1'b1;
  assign bus.UART_TX_O       = tx_q;
  assign bus.Busy            = busy_q;
  assign bus.Done            = done_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Directed bench for sram_uart_tx_interface with a 2-cycle-latency SRAM model.
// Covers 8N1 by default and 8E1 when SRAM_UART_TX_PARITY_EN is defined.
module tb_sram_uart_tx_interface;

  localparam int CPB = 4;
`ifdef SRAM_UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int WORD_CYC = 3 + 2 * F * CPB;

  // ---------------- clock / reset ----------------
  logic       Clock = 1'b0;
  logic       Reset;
  logic [2:0] dbg_state;

  sram_uart_tx_interface_if bus();

  sram_uart_tx_interface #(.CLOCKS_PER_BIT(CPB)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 Clock = ~Clock;

  // ---------------- SRAM model: data two cycles after the address ----------------
  logic [15:0] sram_mem [bit [17:0]];
  logic [15:0] rd_p1, rd_p2;

  function automatic logic [15:0] lookup(input logic [17:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return 16'h0000;
  endfunction

  always @(posedge Clock) begin
    rd_p1 <= lookup(bus.SRAM_address);
    rd_p2 <= rd_p1;
  end
  assign bus.SRAM_read_data = rd_p2;

  // ---------------- scoreboard ----------------
  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame position i: 0 start, 1..8 data LSB first, then parity (8E1 only), then stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && F == 11) return ^b;
    return 1'b1;
  endfunction

  task automatic push_word(input logic [15:0] w);
    logic [7:0] b;
    repeat (3) exp_q.push_back(1'b1);
    for (int by = 0; by < 2; by++) begin
      b = (by == 0) ? w[15:8] : w[7:0];
      for (int i = 0; i < F; i++)
        repeat (CPB) exp_q.push_back(frame_bit(b, i));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Cycle 0 is the cycle Start is high; Done is expected in cycle count*WORD_CYC+1.
  task automatic run_xfer(input logic [17:0] base, input logic [17:0] count, input int poke_cycle);
    int          d;
    logic [17:0] a;
    exp_q = {};
    for (int w = 0; w < int'(count); w++) begin
      a = base + 18'(w);
      push_word(lookup(a));
    end
    d = int'(count) * WORD_CYC + 1;

    @(negedge Clock);
    bus.Start        = 1'b1;
    bus.Base_address = base;
    bus.Word_count   = count;
    @(negedge Clock);
    bus.Start = 1'b0;
    for (int c = 1; c <= d; c++) begin
      if (c > 1) @(negedge Clock);
      if (c == poke_cycle) begin
        bus.Start        = 1'b1;
        bus.Base_address = 18'h2AAAA;
        bus.Word_count   = 18'd5;
      end else if (c == poke_cycle + 1) begin
        bus.Start = 1'b0;
      end
      if (c < d) begin
        check($sformatf("line/done/busy b%0h c%0d", base, c),
              {bus.UART_TX_O, bus.Done, bus.Busy}, {exp_q.pop_front(), 1'b0, 1'b1});
        if ((c - 1) % WORD_CYC == 0) begin
          a = base + 18'((c - 1) / WORD_CYC);
          check($sformatf("rd_addr b%0h c%0d", base, c), bus.SRAM_address, a);
        end
      end else begin
        check($sformatf("done_pulse b%0h", base), {bus.UART_TX_O, bus.Done, bus.Busy}, 3'b110);
        check($sformatf("idle_state b%0h", base), dbg_state, 3'd0);
      end
    end
    @(negedge Clock);
    check($sformatf("done_clear b%0h", base), {bus.UART_TX_O, bus.Done, bus.Busy}, 3'b100);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " tx"},    bus.UART_TX_O, 1'b1);
    check({tag, " busy"},  bus.Busy, 1'b0);
    check({tag, " done"},  bus.Done, 1'b0);
    check({tag, " addr"},  bus.SRAM_address, 18'h0);
    check({tag, " state"}, dbg_state, 3'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset            = 1'b1;
    bus.Start        = 1'b0;
    bus.Base_address = '0;
    bus.Word_count   = '0;
    sram_mem[18'h00010] = 16'hA55A;
    sram_mem[18'h3FFFF] = 16'h1234;
    sram_mem[18'h00000] = 16'hBEEF;
    sram_mem[18'h00100] = 16'h00FF;
    sram_mem[18'h00101] = 16'h8001;
    sram_mem[18'h00020] = 16'h0700;

    #1;
    check_reset_values("async_reset");
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check_reset_values("after_reset");
    check("we_n", bus.SRAM_we_n, 1'b1);
    check("wdata", bus.SRAM_write_data, 16'h0000);

    run_xfer(18'h00010, 18'd1, 0);   // A55A single word
    run_xfer(18'h00000, 18'd0, 0);   // zero count: immediate Done, never busy
    run_xfer(18'h3FFFF, 18'd2, 0);   // address wrap to 0
    run_xfer(18'h00100, 18'd2, 20);  // Start re-asserted mid-transfer

    // Reset during the data bits of the first byte.
    @(negedge Clock);
    bus.Start        = 1'b1;
    bus.Base_address = 18'h00010;
    bus.Word_count   = 18'd1;
    @(negedge Clock);
    bus.Start = 1'b0;
    repeat (15) @(negedge Clock);
    check("mid_frame_busy", bus.Busy, 1'b1);
    check("mid_frame_state", dbg_state, 3'd5);
    #2 Reset = 1'b1;
    #1;
    check_reset_values("mid_frame_reset");
    @(posedge Clock);
    #1 Reset = 1'b0;
    run_xfer(18'h00010, 18'd1, 0);   // fresh transfer right after reset

    run_xfer(18'h00020, 18'd1, 0);   // 0x0700: parity 1 then 0 in the 8E1 build

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
